// File: rtl/cvp14_core.sv
// cvp14_core: multi-cycle 16-bit vector core. Each instruction takes FETCH + DECODE + EXEC (1-4 cycles) or MEM (1-5 cycles).
// Memory is assumed always ready: read data returns one cycle after RD, writes complete on the WR edge.
module cvp14_core (
    input  logic        Clk1,
    input  logic        Reset,
    output logic [15:0] Addr,
    output logic        RD,
    output logic        WR,
    output logic [15:0] DataOut,
    input  logic [15:0] DataIn,
    output logic        V
);

    localparam logic [3:0] OP_VADD = 4'h0;
    localparam logic [3:0] OP_VDOT = 4'h1;
    localparam logic [3:0] OP_SMUL = 4'h2;
    localparam logic [3:0] OP_SADD = 4'h3;
    localparam logic [3:0] OP_SLL  = 4'h4;
    localparam logic [3:0] OP_SLH  = 4'h5;
    localparam logic [3:0] OP_SLD  = 4'h6;
    localparam logic [3:0] OP_SST  = 4'h7;
    localparam logic [3:0] OP_VLD  = 4'h8;
    localparam logic [3:0] OP_VST  = 4'h9;
    localparam logic [3:0] OP_BZ   = 4'hA;
    localparam logic [3:0] OP_J    = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [33:0] acc_q, acc_d;
    logic        vf_q, vf_d;
    logic [15:0] s_q [8];
    logic [15:0] v_q [8][4];

    // register-file write ports driven by the datapath process
    logic        s_we;
    logic [2:0]  s_wa;
    logic [15:0] s_wdat;
    logic [3:0]  v_we;
    logic [2:0]  v_wa;
    logic [15:0] v_wdat [4];

    logic [3:0]  op;
    logic [2:0]  rd, ra, rb;
    logic [1:0]  ei, cap_idx;
    assign op      = ir_q[15:12];
    assign rd      = ir_q[11:9];
    assign ra      = ir_q[8:6];
    assign rb      = ir_q[5:3];
    assign ei      = cnt_q[1:0];
    assign cap_idx = cnt_q[1:0] - 2'd1;

    logic        is_multi, is_load, is_vec_mem, mem_done;
    logic [2:0]  mem_n;
    logic [15:0] mem_base, mem_addr;
    assign is_multi   = (op == OP_VDOT) || (op == OP_SMUL);
    assign is_load    = (op == OP_SLD)  || (op == OP_VLD);
    assign is_vec_mem = (op == OP_VLD)  || (op == OP_VST);
    assign mem_n      = is_vec_mem ? 3'd4 : 3'd1;
    assign mem_base   = is_vec_mem ? s_q[ra] : s_q[ra] + {{10{ir_q[5]}}, ir_q[5:0]};
    assign mem_addr   = mem_base + {13'd0, cnt_q};
    // loads issue back-to-back reads and need one trailing cycle to capture the last word
    assign mem_done   = is_load ? (cnt_q == mem_n) : (cnt_q == mem_n - 3'd1);

    // one shared multiplier: element i of Va times Vb[i] (VDOT) or Sb (SMUL)
    logic [15:0] mul_a, mul_b;
    logic [31:0] mul_ax, mul_bx, prod;
    logic [33:0] acc_sum;
    logic        prod_ovf, acc_ovf;
    assign mul_a    = v_q[ra][ei];
    assign mul_b    = (op == OP_VDOT) ? v_q[rb][ei] : s_q[rb];
    assign mul_ax   = {{16{mul_a[15]}}, mul_a};
    assign mul_bx   = {{16{mul_b[15]}}, mul_b};
    assign prod     = mul_ax * mul_bx;
    assign prod_ovf = prod[31:15] != {17{prod[15]}};
    assign acc_sum  = ((ei == 2'd0) ? 34'd0 : acc_q) + {{2{prod[31]}}, prod};
    assign acc_ovf  = acc_sum[33:15] != {19{acc_sum[15]}};

    function automatic logic add_ovf(input logic [15:0] x, input logic [15:0] y, input logic [15:0] r);
        return (x[15] == y[15]) && (r[15] != x[15]);
    endfunction

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (DataIn[15:12])
                    OP_SLD, OP_SST, OP_VLD, OP_VST: state_d = S_MEM;
                    OP_HALT:                        state_d = S_HALT;
                    default:                        state_d = S_EXEC;
                endcase
            end
            S_EXEC:   if (!is_multi || ei == 2'd3) state_d = S_FETCH;
            S_MEM:    if (mem_done) state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        RD      = 1'b0;
        WR      = 1'b0;
        Addr    = 16'd0;
        DataOut = 16'd0;
        if (!Reset) begin
            case (state_q)
                S_FETCH: begin
                    RD   = 1'b1;
                    Addr = pc_q;
                end
                S_MEM: begin
                    if (is_load) begin
                        if (cnt_q < mem_n) begin
                            RD   = 1'b1;
                            Addr = mem_addr;
                        end
                    end else begin
                        WR      = 1'b1;
                        Addr    = mem_addr;
                        DataOut = is_vec_mem ? v_q[rd][ei] : s_q[rd];
                    end
                end
                default: ;
            endcase
        end
    end

    assign V = vf_q;

    logic        update_pc, set_pc;
    logic [15:0] br_tgt, sadd_sum;
    logic [15:0] vsum [4];
    assign sadd_sum = s_q[ra] + s_q[rb];

    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        vf_d      = vf_q;
        s_we      = 1'b0;
        s_wa      = rd;
        s_wdat    = 16'd0;
        v_we      = 4'd0;
        v_wa      = rd;
        update_pc = 1'b0;
        set_pc    = 1'b0;
        br_tgt    = pc_q;
        for (int i = 0; i < 4; i++) begin
            v_wdat[i] = 16'd0;
            vsum[i]   = v_q[ra][i] + v_q[rb][i];
        end
        case (state_q)
            S_DECODE: begin
                update_pc = 1'b1;
                ir_d      = DataIn;
                cnt_d     = 3'd0;
            end
            S_EXEC: begin
                cnt_d = cnt_q + 3'd1;
                case (op)
                    OP_VADD: begin
                        v_we = 4'hF;
                        for (int i = 0; i < 4; i++) begin
                            v_wdat[i] = vsum[i];
                            if (add_ovf(v_q[ra][i], v_q[rb][i], vsum[i])) vf_d = 1'b1;
                        end
                    end
                    OP_VDOT: begin
                        acc_d = acc_sum;
                        if (prod_ovf) vf_d = 1'b1;
                        if (ei == 2'd3) begin
                            s_we   = 1'b1;
                            s_wdat = acc_sum[15:0];
                            if (acc_ovf) vf_d = 1'b1;
                        end
                    end
                    OP_SMUL: begin
                        v_we       = 4'b0001 << ei;
                        v_wdat[ei] = prod[15:0];
                        if (prod_ovf) vf_d = 1'b1;
                    end
                    OP_SADD: begin
                        s_we   = 1'b1;
                        s_wdat = sadd_sum;
                        if (add_ovf(s_q[ra], s_q[rb], sadd_sum)) vf_d = 1'b1;
                    end
                    OP_SLL: begin
                        s_we   = 1'b1;
                        s_wdat = {s_q[rd][15:8], ir_q[7:0]};
                    end
                    OP_SLH: begin
                        s_we   = 1'b1;
                        s_wdat = {ir_q[7:0], s_q[rd][7:0]};
                    end
                    // pc_q already points past the branch, so targets are relative to PC+1
                    OP_BZ: begin
                        if (s_q[rd] == 16'd0) begin
                            set_pc = 1'b1;
                            br_tgt = pc_q + {{7{ir_q[8]}}, ir_q[8:0]};
                        end
                    end
                    OP_J: begin
                        set_pc = 1'b1;
                        br_tgt = pc_q + {{4{ir_q[11]}}, ir_q[11:0]};
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                cnt_d = cnt_q + 3'd1;
                if (is_load && cnt_q != 3'd0) begin
                    if (is_vec_mem) begin
                        v_we            = 4'b0001 << cap_idx;
                        v_wdat[cap_idx] = DataIn;
                    end else begin
                        s_we   = 1'b1;
                        s_wdat = DataIn;
                    end
                end
            end
            default: ;
        endcase
        if (update_pc) begin
            pc_d = pc_q + 16'd1;
        end else if (set_pc) begin
            pc_d = br_tgt;
        end
    end

    always_ff @(posedge Clk1) begin
        if (Reset) begin
            pc_q  <= 16'd0;
            ir_q  <= 16'd0;
            cnt_q <= 3'd0;
            acc_q <= 34'd0;
            vf_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                s_q[i] <= 16'd0;
                for (int j = 0; j < 4; j++) begin
                    v_q[i][j] <= 16'd0;
                end
            end
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            vf_q  <= vf_d;
            if (s_we) s_q[s_wa] <= s_wdat;
            for (int j = 0; j < 4; j++) begin
                if (v_we[j]) v_q[v_wa][j] <= v_wdat[j];
            end
        end
    end

endmodule

// File: tb/tb_cvp14_core.sv
// Bench for cvp14_core: instruction-level reference model predicts the bus trace and V flag.
module tb_cvp14_core;

    logic        Clk1;
    logic        Reset;
    logic [15:0] Addr;
    logic        RD;
    logic        WR;
    logic [15:0] DataOut;
    logic [15:0] DataIn;
    logic        V;

    cvp14_core dut (
        .Clk1    (Clk1),
        .Reset   (Reset),
        .Addr    (Addr),
        .RD      (RD),
        .WR      (WR),
        .DataOut (DataOut),
        .DataIn  (DataIn),
        .V       (V)
    );

    initial Clk1 = 1'b0;
    always #5 Clk1 = ~Clk1;

    // memory: registered read, write on WR edge, plus a bench load port
    logic [15:0] mem [65536];
    logic [15:0] din_q;
    logic        ld_en;
    logic [15:0] ld_addr, ld_dat;
    assign DataIn = din_q;

    always @(posedge Clk1) begin
        if (ld_en) mem[ld_addr] <= ld_dat;
        else if (WR) mem[Addr] <= DataOut;
        if (RD) din_q <= mem[Addr];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // reference model
    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] dat;
        logic        chkv;
        logic        v;
    } op_t;

    op_t         expq [$];
    logic [15:0] obs_rd [$];
    logic [15:0] mmem [65536];
    logic [15:0] ms [8];
    logic [15:0] mv [8][4];
    logic [15:0] mpc;
    logic        mvf;
    logic        chk_en;

    function automatic longint sx(input logic [15:0] x);
        return longint'($signed(x));
    endfunction

    function automatic logic ovr(input longint x);
        return (x > 32767) || (x < -32768);
    endfunction

    task automatic push_op(input logic wr, input logic [15:0] a, input logic [15:0] d, input logic fetch);
        op_t o;
        o.wr = wr; o.addr = a; o.dat = d; o.chkv = fetch; o.v = mvf;
        expq.push_back(o);
    endtask

    task automatic model_reset();
        mpc = 16'd0;
        mvf = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ms[i] = 16'd0;
            for (int j = 0; j < 4; j++) mv[i][j] = 16'd0;
        end
    endtask

    task automatic model_run();
        int          steps;
        logic        halted;
        logic [15:0] ir, a16;
        logic [3:0]  op;
        int          d, a, b;
        longint      r, sum;
        steps = 0;
        halted = 1'b0;
        while (!halted && steps < 500) begin
            ir = mmem[mpc];
            push_op(1'b0, mpc, 16'd0, 1'b1);
            mpc = mpc + 16'd1;
            steps++;
            op = ir[15:12]; d = int'(ir[11:9]); a = int'(ir[8:6]); b = int'(ir[5:3]);
            a16 = ms[a] + {{10{ir[5]}}, ir[5:0]};
            case (op)
                4'h0: for (int i = 0; i < 4; i++) begin
                    r = sx(mv[a][i]) + sx(mv[b][i]);
                    if (ovr(r)) mvf = 1'b1;
                    mv[d][i] = r[15:0];
                end
                4'h1: begin
                    sum = 0;
                    for (int i = 0; i < 4; i++) begin
                        r = sx(mv[a][i]) * sx(mv[b][i]);
                        if (ovr(r)) mvf = 1'b1;
                        sum += r;
                    end
                    if (ovr(sum)) mvf = 1'b1;
                    ms[d] = sum[15:0];
                end
                4'h2: for (int i = 0; i < 4; i++) begin
                    r = sx(mv[a][i]) * sx(ms[b]);
                    if (ovr(r)) mvf = 1'b1;
                    mv[d][i] = r[15:0];
                end
                4'h3: begin
                    r = sx(ms[a]) + sx(ms[b]);
                    if (ovr(r)) mvf = 1'b1;
                    ms[d] = r[15:0];
                end
                4'h4: ms[d][7:0]  = ir[7:0];
                4'h5: ms[d][15:8] = ir[7:0];
                4'h6: begin
                    push_op(1'b0, a16, 16'd0, 1'b0);
                    ms[d] = mmem[a16];
                end
                4'h7: begin
                    push_op(1'b1, a16, ms[d], 1'b0);
                    mmem[a16] = ms[d];
                end
                4'h8: for (int i = 0; i < 4; i++) begin
                    a16 = ms[a] + 16'(i);
                    push_op(1'b0, a16, 16'd0, 1'b0);
                    mv[d][i] = mmem[a16];
                end
                4'h9: for (int i = 0; i < 4; i++) begin
                    a16 = ms[a] + 16'(i);
                    push_op(1'b1, a16, mv[d][i], 1'b0);
                    mmem[a16] = mv[d][i];
                end
                4'hA: if (ms[d] == 16'd0) mpc = mpc + {{7{ir[8]}}, ir[8:0]};
                4'hB: mpc = mpc + {{4{ir[11]}}, ir[11:0]};
                4'hF: halted = 1'b1;
                default: ;
            endcase
        end
    endtask

    // compare process: every bus operation is matched against the predicted trace
    always @(negedge Clk1) begin
        op_t e;
        if (chk_en && !Reset && (RD || WR)) begin
            check("rd/wr exclusive", {63'd0, RD & WR}, 64'd0);
            if (RD) obs_rd.push_back(Addr);
            if (expq.size() == 0) begin
                n_checks++;
                $display("FAIL extra bus op: RD=%0d WR=%0d Addr=0x%0h, expected bus idle", RD, WR, Addr);
            end else begin
                e = expq.pop_front();
                check("bus op", {WR, Addr, WR ? DataOut : 16'h0}, {e.wr, e.addr, e.wr ? e.dat : 16'h0});
                if (e.chkv) check("V at fetch", {63'd0, V}, {63'd0, e.v});
            end
        end
    end

    task automatic put_word(input logic [15:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_dat = d;
        mmem[a] = d;
        @(posedge Clk1); #1;
        ld_en = 1'b0;
    endtask

    task automatic begin_test();
        Reset = 1'b1;
        chk_en = 1'b0;
        for (int i = 0; i < 16'h60; i++) put_word(16'(i), 16'h0);
        put_word(16'hFFFE, 16'h0);
        put_word(16'hFFFF, 16'h0);
    endtask

    task automatic load_prog(input logic [15:0] p [$]);
        foreach (p[i]) put_word(16'(i), p[i]);
    endtask

    task automatic release_reset();
        @(negedge Clk1);
        check("reset bus outputs", {RD, WR, Addr, DataOut}, 64'd0);
        check("reset V", {63'd0, V}, 64'd0);
        model_reset();
        expq.delete();
        obs_rd.delete();
        model_run();
        @(posedge Clk1); #1;
        chk_en = 1'b1;
        Reset = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin
            @(posedge Clk1);
            n++;
        end
        check("trace drained", 64'(expq.size()), 64'd0);
        repeat (12) @(posedge Clk1);
        #1;
        check("V final", {63'd0, V}, {63'd0, mvf});
    endtask

    logic [15:0] prog [$];
    logic [15:0] seq5 [12] = '{16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd3, 16'd4, 16'd5, 16'd9, 16'd10, 16'd11, 16'd12};
    logic        found;

    initial begin
        Reset = 1'b1; ld_en = 1'b0; ld_addr = 16'd0; ld_dat = 16'd0; chk_en = 1'b0;

        // HALT at address 0
        begin_test();
        prog = '{16'hF000};
        load_prog(prog);
        release_reset();
        drain(200);
        check("halt fetch count", 64'(obs_rd.size()), 64'd1);
        if (obs_rd.size() > 0) check("halt fetch addr", 64'(obs_rd[0]), 64'd0);

        // SLL/SLH/SST
        begin_test();
        prog = '{16'h4234, 16'h5212, 16'h7205, 16'hF000};
        load_prog(prog);
        release_reset();
        drain(200);
        check("mem[5]", 64'(mem[5]), 64'h1234);
        check("model mem[5]", 64'(mmem[5]), 64'h1234);

        // vector load / VADD / VST / VDOT / SMUL
        begin_test();
        prog = '{16'h4020, 16'h8200, 16'h4024, 16'h8400, 16'h0650, 16'h4030, 16'h9600,
                 16'h1850, 16'h7808, 16'h4C03, 16'h2A70, 16'h4040, 16'h9A00, 16'hF000};
        load_prog(prog);
        for (int i = 0; i < 8; i++) put_word(16'h20 + 16'(i), 16'(i + 1));
        release_reset();
        drain(400);
        check("vadd[0]", 64'(mem[16'h30]), 64'd6);
        check("vadd[1]", 64'(mem[16'h31]), 64'd8);
        check("vadd[2]", 64'(mem[16'h32]), 64'd10);
        check("vadd[3]", 64'(mem[16'h33]), 64'd12);
        check("vdot", 64'(mem[16'h38]), 64'h46);
        check("model vdot", 64'(mmem[16'h38]), 64'h46);
        check("smul[2]", 64'(mem[16'h42]), 64'd9);
        check("smul[3]", 64'(mem[16'h43]), 64'd12);

        // SADD overflow, sticky V, VLD wrapping past 0xFFFF
        begin_test();
        prog = '{16'h42FF, 16'h527F, 16'h4401, 16'h3650, 16'h7610, 16'h3890, 16'h7811,
                 16'h4AFE, 16'h5AFF, 16'h8D40, 16'h4C50, 16'h9D80, 16'hF000};
        load_prog(prog);
        put_word(16'hFFFE, 16'hAAAA);
        put_word(16'hFFFF, 16'hBBBB);
        release_reset();
        drain(400);
        check("sadd wrap", 64'(mem[16'h10]), 64'h8000);
        check("sadd small", 64'(mem[16'h11]), 64'h2);
        check("V sticky", {63'd0, V}, 64'd1);
        check("wrap ld[0]", 64'(mem[16'h50]), 64'hAAAA);
        check("wrap ld[1]", 64'(mem[16'h51]), 64'hBBBB);
        check("wrap ld[2]", 64'(mem[16'h52]), 64'h42FF);
        check("wrap ld[3]", 64'(mem[16'h53]), 64'h527F);

        // BZ taken backwards once, then J +3
        begin_test();
        prog = '{16'h44FF, 16'h54FF, 16'h4601, 16'h3498, 16'hA5FE, 16'hB003,
                 16'hF000, 16'hF000, 16'hF000, 16'h7410, 16'hC000, 16'hE000, 16'hF000};
        load_prog(prog);
        release_reset();
        drain(400);
        check("fetch count", 64'(obs_rd.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < obs_rd.size()) check("fetch pc", 64'(obs_rd[i]), 64'(seq5[i]));
        end
        check("branch store", 64'(mem[16'h10]), 64'h1);

        // reset during VST element 2
        begin_test();
        prog = '{16'h4020, 16'h8200, 16'h4024, 16'h8400, 16'h0650, 16'h4030, 16'h9600, 16'hF000};
        load_prog(prog);
        for (int i = 0; i < 8; i++) put_word(16'h20 + 16'(i), 16'(i + 1));
        for (int i = 0; i < 4; i++) put_word(16'h30 + 16'(i), 16'hDEAD);
        release_reset();
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge Clk1);
            if (WR && Addr == 16'h0031) found = 1'b1;
        end
        check("abort trigger seen", {63'd0, found}, 64'd1);
        @(posedge Clk1); #1;
        Reset = 1'b1;
        chk_en = 1'b0;
        @(posedge Clk1); #1;
        check("abort elem0", 64'(mem[16'h30]), 64'd6);
        check("abort elem1", 64'(mem[16'h31]), 64'd8);
        check("abort elem2", 64'(mem[16'h32]), 64'hDEAD);
        check("abort elem3", 64'(mem[16'h33]), 64'hDEAD);
        Reset = 1'b0;
        @(negedge Clk1);
        check("fetch after reset", {RD, WR, Addr}, {1'b1, 1'b0, 16'h0000});
        @(posedge Clk1); #1;
        Reset = 1'b1;
        repeat (2) @(posedge Clk1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
